// File: rtl/execute_stage_pkg.sv
// Shared Y86-64 constants for the execute stage: instruction codes, ALU ops,
// condition codes and the registered result record.
package execute_stage_pkg;

  typedef enum logic [3:0] {
    I_HALT   = 4'h0,
    I_NOP    = 4'h1,
    I_RRMOVQ = 4'h2,
    I_IRMOVQ = 4'h3,
    I_RMMOVQ = 4'h4,
    I_MRMOVQ = 4'h5,
    I_OPQ    = 4'h6,
    I_JXX    = 4'h7,
    I_CALL   = 4'h8,
    I_RET    = 4'h9,
    I_PUSHQ  = 4'hA,
    I_POPQ   = 4'hB
  } icode_e;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_XOR = 2'b11
  } alu_op_e;

  typedef enum logic [3:0] {
    C_YES = 4'h0,
    C_LE  = 4'h1,
    C_L   = 4'h2,
    C_E   = 4'h3,
    C_NE  = 4'h4,
    C_GE  = 4'h5,
    C_G   = 4'h6
  } cond_e;

  localparam logic [3:0]  RNONE      = 4'hF;
  localparam logic [63:0] STACK_STEP = 64'd8;
  // cc packing is {ZF, SF, OF}
  localparam logic [2:0]  CC_RESET   = 3'b100;

  typedef struct packed {
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [63:0] val_e;
    logic [63:0] val_a;
    logic [3:0]  dst_e;
    logic [3:0]  dst_m;
    logic        cnd;
  } ex_result_t;

  localparam ex_result_t RESULT_RESET = '{4'h0, 4'h0, 64'h0, 64'h0, RNONE, RNONE, 1'b0};

  function automatic logic cond_holds(input logic [3:0] ifun, input logic [2:0] cc);
    logic zf, sf, of;
    {zf, sf, of} = cc;
    case (ifun)
      C_YES:   cond_holds = 1'b1;
      C_LE:    cond_holds = (sf ^ of) | zf;
      C_L:     cond_holds = sf ^ of;
      C_E:     cond_holds = zf;
      C_NE:    cond_holds = !zf;
      C_GE:    cond_holds = !(sf ^ of);
      C_G:     cond_holds = !(sf ^ of) && !zf;
      default: cond_holds = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/execute_stage_if.sv
// Decode->execute->memory handshake bundle. The master drives instructions in
// and accepts results; the slave is the execute stage.
interface execute_stage_if;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_icode;
  logic [3:0]  in_ifun;
  logic [63:0] in_valA;
  logic [63:0] in_valB;
  logic [63:0] in_valC;
  logic [3:0]  in_dstE;
  logic [3:0]  in_dstM;

  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_icode;
  logic [3:0]  out_ifun;
  logic [63:0] out_valE;
  logic [63:0] out_valA;
  logic [3:0]  out_dstE;
  logic [3:0]  out_dstM;
  logic        out_cnd;

  modport master (
    output in_valid, in_icode, in_ifun, in_valA, in_valB, in_valC, in_dstE, in_dstM,
    output out_ready,
    input  in_ready,
    input  out_valid, out_icode, out_ifun, out_valE, out_valA, out_dstE, out_dstM, out_cnd
  );

  modport slave (
    input  in_valid, in_icode, in_ifun, in_valA, in_valB, in_valC, in_dstE, in_dstM,
    input  out_ready,
    output in_ready,
    output out_valid, out_icode, out_ifun, out_valE, out_valA, out_dstE, out_dstM, out_cnd
  );
endinterface

// File: rtl/execute_stage_alu.sv
// 64-bit Y86 ALU: result = X op Y with signed-overflow flag for add/sub.
module execute_stage_alu
  import execute_stage_pkg::*;
(
  input  alu_op_e     op,
  input  logic [63:0] x,
  input  logic [63:0] y,
  output logic [63:0] result,
  output logic        overflow
);

  always_comb begin
    result   = '0;
    overflow = 1'b0;
    case (op)
      ALU_ADD: begin
        result   = x + y;
        overflow = (x[63] == y[63]) && (result[63] != x[63]);
      end
      ALU_SUB: begin
        result   = x - y;
        overflow = (x[63] != y[63]) && (result[63] != x[63]);
      end
      ALU_AND: result = x & y;
      ALU_XOR: result = x ^ y;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/execute_stage.sv
// Y86-64 execute stage: one-deep registered result with valid/ready on both
// sides, condition-code register and a sticky halt state.
module execute_stage
  import execute_stage_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  execute_stage_if.slave    bus,
  output logic [2:0]        cc,
  output logic              halted
);

  typedef enum logic {S_RUN, S_HALTED} state_e;

  state_e      state_q, state_d;
  ex_result_t  res_q, res_d;
  logic        out_valid_q, out_valid_d;
  logic [2:0]  cc_q, cc_d;

  logic [63:0] alu_a, alu_b, alu_res;
  alu_op_e     alu_op;
  logic        alu_ovf;
  logic        in_ready, accept, cnd;

  always_comb begin
    alu_a  = '0;
    alu_b  = '0;
    alu_op = ALU_ADD;
    case (bus.in_icode)
      I_RRMOVQ: alu_a = bus.in_valA;
      I_IRMOVQ: alu_a = bus.in_valC;
      I_RMMOVQ, I_MRMOVQ: begin
        alu_a = bus.in_valC;
        alu_b = bus.in_valB;
      end
      I_OPQ: begin
        alu_a  = bus.in_valA;
        alu_b  = bus.in_valB;
        alu_op = alu_op_e'(bus.in_ifun[1:0]);
      end
      I_CALL, I_PUSHQ: begin
        alu_a = -STACK_STEP;
        alu_b = bus.in_valB;
      end
      I_RET, I_POPQ: begin
        alu_a = STACK_STEP;
        alu_b = bus.in_valB;
      end
      default: ;
    endcase
  end

  execute_stage_alu u_alu (
    .op       (alu_op),
    .x        (alu_b),
    .y        (alu_a),
    .result   (alu_res),
    .overflow (alu_ovf)
  );

  // cnd reads the registered cc, so an OPq only influences later instructions
  always_comb begin
    in_ready    = (state_q == S_RUN) && (!out_valid_q || bus.out_ready);
    accept      = bus.in_valid && in_ready;
    cnd         = ((bus.in_icode == I_RRMOVQ) || (bus.in_icode == I_JXX))
                  && cond_holds(bus.in_ifun, cc_q);
    state_d     = state_q;
    out_valid_d = out_valid_q;
    res_d       = res_q;
    cc_d        = cc_q;
    if (accept) begin
      out_valid_d = 1'b1;
      res_d.icode = bus.in_icode;
      res_d.ifun  = bus.in_ifun;
      res_d.val_e = alu_res;
      res_d.val_a = bus.in_valA;
      res_d.dst_e = ((bus.in_icode == I_RRMOVQ) && !cnd) ? RNONE : bus.in_dstE;
      res_d.dst_m = bus.in_dstM;
      res_d.cnd   = cnd;
      if (bus.in_icode == I_OPQ)
        cc_d = {(alu_res == '0), alu_res[63], alu_ovf};
      if (bus.in_icode == I_HALT)
        state_d = S_HALTED;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_RUN;
      out_valid_q <= 1'b0;
      res_q       <= RESULT_RESET;
      cc_q        <= CC_RESET;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      res_q       <= res_d;
      cc_q        <= cc_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_icode = res_q.icode;
  assign bus.out_ifun  = res_q.ifun;
  assign bus.out_valE  = res_q.val_e;
  assign bus.out_valA  = res_q.val_a;
  assign bus.out_dstE  = res_q.dst_e;
  assign bus.out_dstM  = res_q.dst_m;
  assign bus.out_cnd   = res_q.cnd;
  assign cc            = cc_q;
  assign halted        = (state_q == S_HALTED);

endmodule

// File: doc/execute_stage.md
EXECUTE_STAGE -- requirements
Module: execute_stage

Interface
REQ-001 SHALL have ports: clk  input  1  rising-edge clock.
REQ-002 SHALL have ports: rst_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have inputs in_valid 1, in_ready output 1: upstream (decode) handshake.
REQ-004 SHALL have inputs in_icode 4, in_ifun 4, in_valA 64, in_valB 64, in_valC 64, in_dstE 4, in_dstM 4: decoded instruction fields.
REQ-005 SHALL have outputs out_valid 1, input out_ready 1: downstream (memory) handshake.
REQ-006 SHALL have outputs out_icode 4, out_ifun 4, out_valE 64, out_valA 64, out_dstE 4, out_dstM 4, out_cnd 1: registered results.
REQ-007 SHALL have outputs cc 3 {ZF,SF,OF} and halted 1.

Function
REQ-008 SHALL accept an instruction when in_valid && in_ready; in_ready = !halted && (!out_valid || out_ready).
REQ-009 SHALL present the accepted instruction's results on out_* on the next clk edge; latency 1 cycle; results held stable while out_valid && !out_ready.
REQ-010 SHALL deassert out_valid after a transfer (out_valid && out_ready) with no simultaneous acceptance; simultaneous transfer and acceptance SHALL reload the register without a bubble.
REQ-011 SHALL select aluA: valA for icode 2,6; valC for 3,4,5; -8 for 8,A; +8 for 9,B; 0 otherwise.
REQ-012 SHALL select aluB: valB for icode 4,5,6,8,9,A,B; 0 for 2,3 and otherwise.
REQ-013 SHALL compute valE = aluB op aluA, 64-bit two's complement, wrap on overflow; op = ifun[1:0] for icode 6 (00 add, 01 sub, 10 and, 11 xor), add for all others.
REQ-014 SHALL update cc on acceptance of icode 6 only: ZF = (valE==0), SF = valE[63], OF = signed overflow of add/sub (0 for and/xor).
REQ-015 SHALL compute cnd from current cc for icode 2,7: ifun 0 always 1; 1 le (SF^OF)|ZF; 2 l SF^OF; 3 e ZF; 4 ne !ZF; 5 ge !(SF^OF); 6 g !(SF^OF)&!ZF; ifun>6 gives 0; cnd = 0 for other icodes.
REQ-016 SHALL force out_dstE = 4'hF for icode 2 when cnd = 0; else pass in_dstE.
REQ-017 SHALL pass valA, dstM, icode, ifun through unchanged.
REQ-018 SHALL implement states RUN and HALTED; accepting icode 0 moves RUN to HALTED at that edge; the halt instruction still issues downstream; HALTED persists until reset.
REQ-019 SHALL evaluate cnd against cc as it stands before the accepting edge; an OPq accepted in cycle N affects jXX/cmov accepted in cycle N+1 onward.

Reset
REQ-020 SHALL on rst_n low, immediately: out_valid=0, all out_* data=0, out_dstE=out_dstM=4'hF, cc={ZF=1,SF=0,OF=0}, state RUN, halted=0.
REQ-021 SHALL discard any held, untransferred result on reset mid-operation; first acceptance possible on the first edge after rst_n rises.

Structure
REQ-022 SHALL take icode encodings, ALU op codes, condition codes (ifun 0-6) and RNONE=4'hF from a shared Y86 constants package.
REQ-023 SHALL instantiate the team's 64-bit alu sub-module (2-bit op, X=aluB, Y=aluA, result, overflow) for valE and OF; no duplicate adder.

Verification
REQ-024 OPq sub: valA=5, valB=5 -> out_valE=0, cc={1,0,0} one cycle after acceptance.
REQ-025 OPq add valA=1, valB=0x7FFF_FFFF_FFFF_FFFF, then jXX ifun 2 (l) next cycle -> valE=0x8000_0000_0000_0000, cc={0,1,1}, jXX out_cnd=0.
REQ-026 cmovle with cc={0,0,0}, in_dstE=3 -> out_cnd=0, out_dstE=4'hF, out_valE=valA.
REQ-027 pushq valB=0x100 with out_ready=0 for 3 cycles -> out_valE=0xF8 held stable, in_ready=0, cc unchanged; transfer when out_ready=1.
REQ-028 halt accepted then in_valid held 1 -> halt issues once, halted=1, in_ready=0 indefinitely; rst_n pulse -> REQ-020 values, in_ready=1.
